updn_mod_counter: RTL and testbench
===================================

UPDN_MOD_COUNTER -- requirements
Module: updn_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, SHALL be >= 2.
REQ-002 Parameter RST_VAL, default 0: count value after reset, SHALL be < 2**WIDTH.
REQ-003 Reset SHALL be rst, asynchronous, active-high; clock SHALL be clk, rising edge.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 en  input  1  count enable; when low, count holds (unless clr/load).
REQ-007 clr  input  1  synchronous clear to 0.
REQ-008 load  input  1  synchronous load of load_val.
REQ-009 load_val  input  WIDTH  value for load.
REQ-010 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-011 sat  input  1  boundary mode: 1 = saturate, 0 = wrap.
REQ-012 max_val  input  WIDTH  inclusive upper bound; lower bound fixed at 0.
REQ-013 count  output  WIDTH  registered count value.
REQ-014 at_max  output  1  combinational, high when count == max_val.
REQ-015 at_min  output  1  combinational, high when count == 0.
REQ-016 wrap_p  output  1  registered one-cycle pulse, high in the cycle after a wrap step.
REQ-017 sat_hit  output  1  registered one-cycle pulse, high in the cycle after a step blocked by saturation.
REQ-018 ovf_sticky  output  1  registered flag, set on any wrap or saturation event, cleared only by clr or rst.

Function
REQ-019 Priority per rising edge SHALL be: clr > load > en; no action when none is asserted.
REQ-020 clr SHALL set count to 0 and ovf_sticky to 0, and SHALL force wrap_p and sat_hit to 0 for that cycle.
REQ-021 load SHALL set count to min(load_val, max_val) and SHALL NOT generate wrap_p or sat_hit.
REQ-022 en with up=1 and count < max_val SHALL set count to count+1.
REQ-023 en with up=0 and count > 0 SHALL set count to count-1.
REQ-024 en, up=1, count == max_val: sat=0 SHALL set count to 0 and pulse wrap_p; sat=1 SHALL hold count and pulse sat_hit.
REQ-025 en, up=0, count == 0: sat=0 SHALL set count to max_val and pulse wrap_p; sat=1 SHALL hold count and pulse sat_hit.
REQ-026 en with count > max_val (max_val lowered at run time) SHALL set count to max_val when sat=1, or to 0 when sat=0, and SHALL pulse sat_hit or wrap_p respectively.
REQ-027 max_val == 0 SHALL keep count at 0 on every en step and SHALL pulse sat_hit (sat=1) or wrap_p (sat=0) on each step.
REQ-028 All arithmetic SHALL be WIDTH bits; no intermediate value SHALL be truncated into an incorrect compare (compare count with max_val before stepping).
REQ-029 Any wrap_p or sat_hit event SHALL set ovf_sticky on the same edge that registers the pulse.
REQ-030 Changes to up, sat or max_val SHALL take effect on the next rising edge; there SHALL be no internal pipeline, and latency from en to count update SHALL be 1 cycle.
REQ-031 at_max and at_min SHALL both be high when count == max_val == 0.

Reset
REQ-032 rst high SHALL immediately set count=RST_VAL, wrap_p=0, sat_hit=0, ovf_sticky=0, independent of clk.
REQ-033 rst asserted mid-count SHALL discard any pending step; the first step after rst deassertion SHALL be taken from RST_VAL.
REQ-034 If RST_VAL > max_val, the first en step after reset SHALL follow REQ-026.

Verification (WIDTH=4, RST_VAL=0 unless stated)
REQ-035 max_val=9, sat=0, up=1, en=1 for 12 cycles -> count 1..9,0,1,2; wrap_p pulses once, in the cycle after 9->0; ovf_sticky=1.
REQ-036 max_val=9, sat=1, up=0, count=1, en for 3 cycles -> count 0,0,0; sat_hit pulses twice; at_min=1.
REQ-037 load=1, load_val=13, max_val=9 -> count=9, at_max=1, no pulses; then clr=1 and load=1 together -> count=0, ovf_sticky=0.
REQ-038 count=8, max_val lowered to 5, en=1: sat=1 -> count=5 with sat_hit; repeated from count=8 with sat=0 -> count=0 with wrap_p.
REQ-039 max_val=15, sat=0, up=0, count=0, en=1 -> count=15 with wrap_p; rst pulsed asynchronously between clock edges -> count=0 immediately, all flags 0.
REQ-040 en=0 with up toggling and max_val changing for 5 cycles -> count constant, no pulses.

Source files
------------

// File: rtl/updn_mod_counter_if.sv
// Control, bound and status bundle for the up/down modulo counter.
// Master drives controls and the bound; slave returns count and flags.
interface updn_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up;
    logic             sat;
    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_min;
    logic             wrap_p;
    logic             sat_hit;
    logic             ovf_sticky;

    modport master (
        output en, clr, load, load_val, up, sat, max_val,
        input  count, at_max, at_min, wrap_p, sat_hit, ovf_sticky
    );

    modport slave (
        input  en, clr, load, load_val, up, sat, max_val,
        output count, at_max, at_min, wrap_p, sat_hit, ovf_sticky
    );
endinterface

// File: rtl/updn_mod_counter.sv
// Up/down counter over [0, max_val] with wrap or saturate at the bounds; 1-cycle step latency.
// No backpressure: every enabled edge steps, with priority clr > load > en.
module updn_mod_counter #(
    parameter int          WIDTH   = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic                clk,
    input  logic                rst,
    updn_mod_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] RST_CNT = RST_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO    = '0;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             sat_hit_q;
    logic             sat_hit_d;
    logic             sticky_q;
    logic             sticky_d;
    logic             bound_evt;

    always_comb begin
        count_d   = count_q;
        bound_evt = 1'b0;
        if (bus.clr) begin
            count_d = ZERO;
        end else if (bus.load) begin
            count_d = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
        end else if (bus.en) begin
            // Out-of-range count (bound lowered under us) is pulled back before any step.
            if (count_q > bus.max_val) begin
                bound_evt = 1'b1;
                count_d   = bus.sat ? bus.max_val : ZERO;
            end else if (bus.up) begin
                if (count_q < bus.max_val) begin
                    count_d = count_q + ONE;
                end else begin
                    bound_evt = 1'b1;
                    count_d   = bus.sat ? count_q : ZERO;
                end
            end else begin
                if (count_q != ZERO) begin
                    count_d = count_q - ONE;
                end else begin
                    bound_evt = 1'b1;
                    count_d   = bus.sat ? ZERO : bus.max_val;
                end
            end
        end
    end

    always_comb begin
        wrap_d    = bound_evt & ~bus.sat;
        sat_hit_d = bound_evt &  bus.sat;
        sticky_d  = bus.clr ? 1'b0 : (sticky_q | bound_evt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= RST_CNT;
            wrap_q    <= 1'b0;
            sat_hit_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            sat_hit_q <= sat_hit_d;
            sticky_q  <= sticky_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.at_max     = (count_q == bus.max_val);
    assign bus.at_min     = (count_q == ZERO);
    assign bus.wrap_p     = wrap_q;
    assign bus.sat_hit    = sat_hit_q;
    assign bus.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_updn_mod_counter.sv
// Scoreboarded random and directed bench for updn_mod_counter against an integer reference model.
module tb_updn_mod_counter;
    localparam int WIDTH   = 4;
    localparam int RST_VAL = 0;
    localparam int MAXC    = (1 << WIDTH) - 1;

    typedef struct {
        int cnt;
        bit wrap;
        bit sh;
        bit stk;
        bit amax;
        bit amin;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    updn_mod_counter_if #(.WIDTH(WIDTH)) bus ();
    updn_mod_counter #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   m_cnt;
    int   m_stk;

    task automatic check(input string name, input logic [31:0] act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected record per clock edge of issued stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("count",      {28'd0, bus.count}, e.cnt);
                check("wrap_p",     {31'd0, bus.wrap_p}, int'(e.wrap));
                check("sat_hit",    {31'd0, bus.sat_hit}, int'(e.sh));
                check("ovf_sticky", {31'd0, bus.ovf_sticky}, int'(e.stk));
                check("at_max",     {31'd0, bus.at_max}, int'(e.amax));
                check("at_min",     {31'd0, bus.at_min}, int'(e.amin));
            end
        end
    end

    // Drive one cycle of inputs and push what the counter must show after the edge.
    task automatic step(input bit e_, input bit c_, input bit l_, input int lv,
                        input bit u_, input bit s_, input int mx);
        exp_t x;
        bit   ev;
        int   nxt;
        @(negedge clk);
        bus.en       = e_;
        bus.clr      = c_;
        bus.load     = l_;
        bus.load_val = lv[WIDTH-1:0];
        bus.up       = u_;
        bus.sat      = s_;
        bus.max_val  = mx[WIDTH-1:0];
        ev  = 1'b0;
        nxt = m_cnt;
        if (c_) begin
            nxt   = 0;
            m_stk = 0;
        end else if (l_) begin
            nxt = (lv < mx) ? lv : mx;
        end else if (e_) begin
            if (m_cnt > mx) begin
                ev  = 1'b1;
                nxt = s_ ? mx : 0;
            end else if (u_) begin
                if (m_cnt < mx) nxt = m_cnt + 1;
                else begin
                    ev  = 1'b1;
                    nxt = s_ ? m_cnt : 0;
                end
            end else begin
                if (m_cnt > 0) nxt = m_cnt - 1;
                else begin
                    ev  = 1'b1;
                    nxt = s_ ? 0 : mx;
                end
            end
        end
        if (ev) m_stk = 1;
        m_cnt  = nxt;
        x.cnt  = nxt;
        x.wrap = ev && !s_;
        x.sh   = ev && s_;
        x.stk  = (m_stk != 0);
        x.amax = (nxt == mx);
        x.amin = (nxt == 0);
        q.push_back(x);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Reset pulse strictly between clock edges; flags must drop without a clock.
    task automatic async_reset();
        settle();
        rst = 1'b1;
        #1;
        check("arst_count",  {28'd0, bus.count}, RST_VAL);
        check("arst_wrap",   {31'd0, bus.wrap_p}, 0);
        check("arst_sathit", {31'd0, bus.sat_hit}, 0);
        check("arst_sticky", {31'd0, bus.ovf_sticky}, 0);
        #1;
        rst   = 1'b0;
        m_cnt = RST_VAL;
        m_stk = 0;
    endtask

    initial begin
        int mx_r;
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.clr      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.up       = 1'b1;
        bus.sat      = 1'b0;
        bus.max_val  = 4'd9;
        m_cnt        = RST_VAL;
        m_stk        = 0;
        #1;
        check("rst_count",  {28'd0, bus.count}, RST_VAL);
        check("rst_sticky", {31'd0, bus.ovf_sticky}, 0);
        check("rst_at_min", {31'd0, bus.at_min}, 1);
        @(negedge clk);
        rst = 1'b0;

        // Wrap upward through 9 -> 0.
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 1, 0, 9);
        settle();
        check("up_wrap_count",  {28'd0, bus.count}, 2);
        check("up_wrap_sticky", {31'd0, bus.ovf_sticky}, 1);

        // Saturate downward at 0.
        step(0, 0, 1, 1, 0, 1, 9);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 9);
        settle();
        check("dn_sat_count", {28'd0, bus.count}, 0);
        check("dn_sat_hit",   {31'd0, bus.sat_hit}, 1);

        // Load above the bound clamps; clr beats load.
        step(0, 0, 1, 13, 1, 0, 9);
        settle();
        check("load_clamp", {28'd0, bus.count}, 9);
        check("load_atmax", {31'd0, bus.at_max}, 1);
        step(0, 1, 1, 7, 1, 0, 9);
        settle();
        check("clr_over_load", {28'd0, bus.count}, 0);
        check("clr_sticky",    {31'd0, bus.ovf_sticky}, 0);

        // Bound lowered below the count.
        step(0, 0, 1, 8, 1, 1, 15);
        step(1, 0, 0, 0, 1, 1, 5);
        settle();
        check("lower_sat", {28'd0, bus.count}, 5);
        step(0, 0, 1, 8, 1, 0, 15);
        step(1, 0, 0, 0, 1, 0, 5);
        settle();
        check("lower_wrap", {28'd0, bus.wrap_p}, 1);

        // max_val == 0 in both modes and directions.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, i[0], i[1], 0);

        // Down-wrap to full scale, then asynchronous reset mid-count.
        step(0, 1, 0, 0, 0, 0, 15);
        step(1, 0, 0, 0, 0, 0, 15);
        settle();
        check("dn_wrap_full", {28'd0, bus.count}, 15);
        async_reset();
        step(1, 0, 0, 0, 1, 0, 15);

        // Disabled: count must hold while up and max_val churn.
        step(0, 0, 1, 6, 1, 0, 9);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, i[0], 0, 6 + i);
        settle();
        check("hold_count", {28'd0, bus.count}, 6);

        mx_r = 9;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) mx_r = $urandom_range(0, MAXC);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, MAXC),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, mx_r);
            if (i % 97 == 96) async_reset();
        end

        settle();
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
